// File: rtl/stream_rr_arbiter.sv
// Burst-granular round-robin arbiter: IN_NB valid/ready streams onto one output, one grant = BURST_NB beats.
// Latency 1 cycle (OUT_PIPE=1) or 0; backpressure stalls the granted requester only. Optional check: STREAM_RR_ARB_CHECK_EN.
module stream_rr_arbiter #(
    parameter int OP_W     = 32,
    parameter int COEF     = 16,
    parameter int IN_NB    = 4,
    parameter int BURST_NB = 8,
    parameter int OUT_PIPE = 1
) (
    input  logic                                   clk,
    input  logic                                   s_rst,
    input  logic [IN_NB-1:0][COEF-1:0][OP_W-1:0]   in_data,
    input  logic [IN_NB-1:0]                       in_vld,
    output logic [IN_NB-1:0]                       in_rdy,
    output logic [COEF-1:0][OP_W-1:0]              out_data,
    output logic                                   out_vld,
    input  logic                                   out_rdy,
    output logic [$clog2(IN_NB)-1:0]               out_src,
    output logic                                   out_last,
    output logic                                   error
);
    localparam int SRC_W = $clog2(IN_NB);
    localparam int CNT_W = (BURST_NB > 1) ? $clog2(BURST_NB) : 1;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;
    localparam logic [SRC_W-1:0] PTR_RST  = SRC_W'(IN_NB - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_NB - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] win_idx;
    logic [SRC_W-1:0] sel;
    logic             win_vld;
    logic             sel_vld;
    logic             acc_rdy;
    logic             accept;
    logic             is_last;

    // Descending scan so the requester closest after rr_ptr overwrites the others.
    always_comb begin
        logic [SRC_W-1:0] k;
        win_vld = 1'b0;
        win_idx = '0;
        k       = '0;
        for (int i = IN_NB; i >= 1; i--) begin
            k = SRC_W'((int'(rr_ptr) + i) % IN_NB);
            if (in_vld[k]) begin
                win_vld = 1'b1;
                win_idx = k;
            end
        end
    end

    assign sel     = (state == ST_IDLE) ? win_idx : grant;
    assign sel_vld = (state == ST_IDLE) ? win_vld : in_vld[grant];
    assign is_last = (beat_cnt == CNT_LAST);
    assign accept  = sel_vld && acc_rdy;

    always_comb begin
        in_rdy = '0;
        if (state == ST_BURST || win_vld) begin
            in_rdy[sel] = acc_rdy;
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            rr_ptr   <= PTR_RST;
            grant    <= '0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                grant  <= win_idx;
                rr_ptr <= win_idx;
            end
            if (is_last) begin
                beat_cnt <= '0;
                state    <= ST_IDLE;
            end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                state    <= ST_BURST;
            end
        end
    end

    generate
        if (OUT_PIPE != 0) begin : g_pipe
            logic                         vld_q;
            logic [SRC_W-1:0]             src_q;
            logic                         last_q;
            logic [COEF-1:0][OP_W-1:0]    data_q;

            // Reset blocks acceptance so a beat arriving during reset is never emitted.
            assign acc_rdy = !s_rst && (!vld_q || out_rdy);

            always_ff @(posedge clk) begin
                if (s_rst) begin
                    vld_q  <= 1'b0;
                    src_q  <= '0;
                    last_q <= 1'b0;
                end else if (acc_rdy) begin
                    vld_q <= accept;
                    if (accept) begin
                        src_q  <= sel;
                        last_q <= is_last;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (accept) begin
                    data_q <= in_data[sel];
                end
            end

            assign out_vld  = vld_q;
            assign out_src  = src_q;
            assign out_last = last_q;
            assign out_data = data_q;
        end else begin : g_comb
            assign acc_rdy  = !s_rst && out_rdy;
            assign out_vld  = !s_rst && sel_vld;
            assign out_src  = sel;
            assign out_last = is_last;
            assign out_data = in_data[sel];
        end
    endgenerate

`ifdef STREAM_RR_ARB_CHECK_EN
    logic error_q;

    always_ff @(posedge clk) begin
        if (s_rst) begin
            error_q <= 1'b0;
        end else if (state == ST_BURST && !in_vld[grant]) begin
            error_q <= 1'b1;
            if (!error_q) begin
                $error("stream_rr_arbiter: in_vld dropped mid-burst at %0t, grant %0d", $time, grant);
            end
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed and randomized bench for stream_rr_arbiter (4 x 8-beat default) plus a 3-way, 1-beat, pass-through instance.
module tb_stream_rr_arbiter;
    logic                    clk = 1'b0;
    logic                    s_rst;
    logic [3:0][15:0][31:0]  in_data;
    logic [3:0]              in_vld;
    logic [3:0]              in_rdy;
    logic [15:0][31:0]       out_data;
    logic                    out_vld;
    logic                    out_rdy;
    logic [1:0]              out_src;
    logic                    out_last;
    logic                    error;

    logic [2:0][0:0][7:0]    b_in_data;
    logic [2:0]              b_in_vld;
    logic [2:0]              b_in_rdy;
    logic [0:0][7:0]         b_out_data;
    logic                    b_out_vld;
    logic                    b_out_rdy;
    logic [1:0]              b_out_src;
    logic                    b_out_last;
    logic                    b_error;

    int tests_run    = 0;
    int tests_failed = 0;

    int seq[4];
    int acc_cnt[4];
    int acc_first[4];
    int cyc;
    logic [1:0]  obs_src[$];
    logic        obs_last[$];
    logic [31:0] obs_word[$];
    int          obs_cyc[$];
    bit          obs_rep[$];

`ifdef STREAM_RR_ARB_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    stream_rr_arbiter dut (
        .clk(clk), .s_rst(s_rst),
        .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_src(out_src), .out_last(out_last), .error(error)
    );

    stream_rr_arbiter #(.OP_W(8), .COEF(1), .IN_NB(3), .BURST_NB(1), .OUT_PIPE(0)) dut_b1 (
        .clk(clk), .s_rst(s_rst),
        .in_data(b_in_data), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
        .out_data(b_out_data), .out_vld(b_out_vld), .out_rdy(b_out_rdy),
        .out_src(b_out_src), .out_last(b_out_last), .error(b_error)
    );

    function automatic logic [31:0] mk(input int r, input int s);
        return {r[7:0], s[23:0]};
    endfunction

    // One clock: drive data from per-source counters, log output transfers and input acceptances.
    task automatic tick();
        logic [3:0] acc;
        for (int r = 0; r < 4; r++) in_data[r] = {16{mk(r, seq[r])}};
        #1;
        acc = in_vld & in_rdy;
        if (out_vld && out_rdy) begin
            obs_src.push_back(out_src);
            obs_last.push_back(out_last);
            obs_word.push_back(out_data[0]);
            obs_cyc.push_back(cyc);
            obs_rep.push_back(out_data == {16{out_data[0]}});
        end
        @(posedge clk);
        for (int r = 0; r < 4; r++) begin
            if (acc[r]) begin
                if (acc_first[r] < 0) acc_first[r] = cyc;
                seq[r]++;
                acc_cnt[r]++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic clear_obs();
        obs_src.delete(); obs_last.delete(); obs_word.delete(); obs_cyc.delete(); obs_rep.delete();
    endtask

    task automatic do_reset();
        s_rst = 1'b1; in_vld = '0; out_rdy = 1'b1; b_in_vld = '0; b_out_rdy = 1'b1;
        tick(); tick();
        s_rst = 1'b0;
        for (int r = 0; r < 4; r++) begin seq[r] = 0; acc_cnt[r] = 0; acc_first[r] = -1; end
        cyc = 0;
        clear_obs();
    endtask

    task automatic test_reset();
        s_rst = 1'b1; in_vld = 4'hF; out_rdy = 1'b1; b_in_vld = '0; b_out_rdy = 1'b1; b_in_data = '0;
        for (int r = 0; r < 4; r++) begin seq[r] = 0; acc_cnt[r] = 0; acc_first[r] = -1; end
        cyc = 0;
        tick(); tick();
        tests_run++; if (out_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
        tests_run++; if (out_src !== 2'd0) begin tests_failed++; $display("FAIL reset_out_src got %0d want 0", out_src); end
        tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last got %b want 0", out_last); end
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error got %b want 0", error); end
        tests_run++; if (in_rdy !== 4'b0000) begin tests_failed++; $display("FAIL reset_in_rdy got %b want 0000", in_rdy); end
        s_rst = 1'b0;
        #1;
        tests_run++; if (in_rdy !== 4'b0001) begin tests_failed++; $display("FAIL reset_first_prio got %b want 0001", in_rdy); end
        in_vld = 4'b1110;
        #1;
        tests_run++; if (in_rdy !== 4'b0010) begin tests_failed++; $display("FAIL reset_scan got %b want 0010", in_rdy); end
        in_vld = '0;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        in_vld = 4'b0100;
        repeat (25) tick();
        tests_run++; if (obs_src.size() != 24) begin tests_failed++; $display("FAIL single_count got %0d want 24", obs_src.size()); end
        for (int k = 0; k < 24 && k < obs_src.size(); k++) begin
            tests_run++;
            if (obs_src[k] !== 2'd2 || obs_word[k] !== mk(2, k) || obs_last[k] !== (k % 8 == 7) || obs_cyc[k] != k + 1 || !obs_rep[k]) begin
                tests_failed++;
                $display("FAIL single_beat%0d got src=%0d word=%h last=%b cyc=%0d rep=%b want src=2 word=%h last=%b cyc=%0d",
                         k, obs_src[k], obs_word[k], obs_last[k], obs_cyc[k], obs_rep[k], mk(2, k), (k % 8 == 7), k + 1);
            end
        end
    endtask

    task automatic test_all_rr();
        do_reset();
        in_vld = 4'hF;
        repeat (129) tick();
        tests_run++; if (obs_src.size() != 128) begin tests_failed++; $display("FAIL rr_count got %0d want 128", obs_src.size()); end
        for (int k = 0; k < 128 && k < obs_src.size(); k++) begin
            int s;
            int q;
            s = (k / 8) % 4;
            q = (k / 32) * 8 + k % 8;
            tests_run++;
            if (obs_src[k] !== 2'(s) || obs_word[k] !== mk(s, q) || obs_last[k] !== (k % 8 == 7) || obs_cyc[k] != k + 1) begin
                tests_failed++;
                $display("FAIL rr_beat%0d got src=%0d word=%h last=%b cyc=%0d want src=%0d word=%h last=%b cyc=%0d",
                         k, obs_src[k], obs_word[k], obs_last[k], obs_cyc[k], s, mk(s, q), (k % 8 == 7), k + 1);
            end
        end
    endtask

    task automatic test_no_interleave();
        do_reset();
        in_vld = 4'b0001;
        repeat (3) tick();
        in_vld = 4'b0011;
        repeat (14) tick();
        tests_run++; if (acc_first[1] != 8) begin tests_failed++; $display("FAIL nointl_r1_first got %0d want 8", acc_first[1]); end
        tests_run++; if (obs_src.size() != 16) begin tests_failed++; $display("FAIL nointl_count got %0d want 16", obs_src.size()); end
        for (int k = 0; k < 16 && k < obs_src.size(); k++) begin
            tests_run++;
            if (obs_src[k] !== 2'(k / 8) || obs_word[k] !== mk(k / 8, k % 8)) begin
                tests_failed++;
                $display("FAIL nointl_beat%0d got src=%0d word=%h want src=%0d word=%h", k, obs_src[k], obs_word[k], k / 8, mk(k / 8, k % 8));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_vld = 4'b1000;
        out_rdy = 1'b0;
        tick();
        repeat (3) begin
            tick();
            tests_run++;
            if (out_vld !== 1'b1 || out_src !== 2'd3 || out_data[0] !== mk(3, 0) || out_last !== 1'b0 || in_rdy !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_hold got vld=%b src=%0d word=%h last=%b in_rdy=%b want 1/3/%h/0/0000",
                         out_vld, out_src, out_data[0], out_last, in_rdy, mk(3, 0));
            end
        end
        out_rdy = 1'b1;
        repeat (8) tick();
        tests_run++; if (obs_src.size() != 8) begin tests_failed++; $display("FAIL bp_count got %0d want 8", obs_src.size()); end
        for (int k = 0; k < 8 && k < obs_src.size(); k++) begin
            tests_run++;
            if (obs_src[k] !== 2'd3 || obs_word[k] !== mk(3, k) || obs_last[k] !== (k == 7) || obs_cyc[k] != 4 + k) begin
                tests_failed++;
                $display("FAIL bp_beat%0d got src=%0d word=%h last=%b cyc=%0d want 3/%h/%b/%0d",
                         k, obs_src[k], obs_word[k], obs_last[k], obs_cyc[k], mk(3, k), (k == 7), 4 + k);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_vld = 4'b0100;
        repeat (3) tick();
        s_rst = 1'b1;
        in_vld = 4'b0101;
        #1;
        tests_run++; if (in_rdy !== 4'b0000) begin tests_failed++; $display("FAIL rstmid_in_rdy_during got %b want 0000", in_rdy); end
        tick();
        tests_run++; if (out_vld !== 1'b0) begin tests_failed++; $display("FAIL rstmid_out_vld got %b want 0", out_vld); end
        tests_run++; if (in_rdy !== 4'b0000) begin tests_failed++; $display("FAIL rstmid_in_rdy got %b want 0000", in_rdy); end
        s_rst = 1'b0;
        clear_obs();
        repeat (17) tick();
        tests_run++; if (obs_src.size() != 16) begin tests_failed++; $display("FAIL rstmid_count got %0d want 16", obs_src.size()); end
        for (int k = 0; k < 16 && k < obs_src.size(); k++) begin
            int s;
            int q;
            s = (k < 8) ? 0 : 2;
            q = (k < 8) ? k : 3 + (k - 8);
            tests_run++;
            if (obs_src[k] !== 2'(s) || obs_word[k] !== mk(s, q) || obs_last[k] !== (k % 8 == 7)) begin
                tests_failed++;
                $display("FAIL rstmid_beat%0d got src=%0d word=%h last=%b want %0d/%h/%b",
                         k, obs_src[k], obs_word[k], obs_last[k], s, mk(s, q), (k % 8 == 7));
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        in_vld = 4'b0010;
        repeat (4) tick();
        in_vld = 4'b0001;
        tick();
        tests_run++; if (error !== ERR_EXP) begin tests_failed++; $display("FAIL drop_error got %b want %b", error, ERR_EXP); end
        tests_run++; if (in_rdy !== 4'b0010) begin tests_failed++; $display("FAIL drop_in_rdy got %b want 0010", in_rdy); end
        tick();
        in_vld = 4'b0011;
        repeat (6) tick();
        tests_run++; if (error !== ERR_EXP) begin tests_failed++; $display("FAIL drop_sticky got %b want %b", error, ERR_EXP); end
        tests_run++; if (obs_src.size() != 9) begin tests_failed++; $display("FAIL drop_count got %0d want 9", obs_src.size()); end
        for (int k = 0; k < 9 && k < obs_src.size(); k++) begin
            int s;
            int q;
            s = (k < 8) ? 1 : 0;
            q = (k < 8) ? k : 0;
            tests_run++;
            if (obs_src[k] !== 2'(s) || obs_word[k] !== mk(s, q) || obs_last[k] !== (k == 7)) begin
                tests_failed++;
                $display("FAIL drop_beat%0d got src=%0d word=%h last=%b want %0d/%h/%b",
                         k, obs_src[k], obs_word[k], obs_last[k], s, mk(s, q), (k == 7));
            end
        end
    endtask

    task automatic test_random();
        int budget;
        int bad_order;
        int bad_burst;
        int bad_last;
        int first_bad;
        int nxt[4];
        logic [1:0] bsrc;
        do_reset();
        budget = 0;
        while (obs_src.size() < 10000 && budget < 60000) begin
            out_rdy = 1'($urandom_range(0, 1));
            for (int r = 0; r < 4; r++) begin
                in_vld[r] = (acc_cnt[r] % 8 != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            tick();
            budget++;
        end
        tests_run++; if (obs_src.size() < 10000) begin tests_failed++; $display("FAIL rand_budget got %0d beats want 10000", obs_src.size()); end
        bad_order = 0; bad_burst = 0; bad_last = 0; first_bad = -1;
        for (int r = 0; r < 4; r++) nxt[r] = 0;
        bsrc = '0;
        for (int k = 0; k < obs_src.size(); k++) begin
            if (k % 8 == 0) bsrc = obs_src[k];
            if (obs_src[k] !== bsrc) begin bad_burst++; if (first_bad < 0) first_bad = k; end
            if (obs_word[k] !== mk(obs_src[k], nxt[obs_src[k]]) || !obs_rep[k]) begin bad_order++; if (first_bad < 0) first_bad = k; end
            if (obs_last[k] !== (k % 8 == 7)) begin bad_last++; if (first_bad < 0) first_bad = k; end
            nxt[obs_src[k]]++;
        end
        tests_run++; if (bad_order != 0) begin tests_failed++; $display("FAIL rand_order got %0d bad beats (first %0d) want 0", bad_order, first_bad); end
        tests_run++; if (bad_burst != 0) begin tests_failed++; $display("FAIL rand_burst got %0d bad beats (first %0d) want 0", bad_burst, first_bad); end
        tests_run++; if (bad_last != 0) begin tests_failed++; $display("FAIL rand_last got %0d bad beats (first %0d) want 0", bad_last, first_bad); end
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL rand_error got %b want 0", error); end
        out_rdy = 1'b1;
    endtask

    task automatic test_burst1();
        do_reset();
        b_in_vld = 3'b111;
        b_out_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            int s;
            for (int r = 0; r < 3; r++) b_in_data[r] = 8'(16 * r + c);
            #1;
            s = c % 3;
            tests_run++;
            if (b_out_vld !== 1'b1 || b_out_src !== 2'(s) || b_out_last !== 1'b1 || b_out_data[0] !== 8'(16 * s + c)
                || b_in_rdy !== 3'(1 << s) || b_error !== 1'b0) begin
                tests_failed++;
                $display("FAIL b1_cycle%0d got vld=%b src=%0d last=%b data=%h in_rdy=%b want 1/%0d/1/%h/%b",
                         c, b_out_vld, b_out_src, b_out_last, b_out_data[0], b_in_rdy, s, 8'(16 * s + c), 3'(1 << s));
            end
            @(posedge clk);
            #1;
        end
        b_in_vld = '0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_all_rr();
        test_no_interleave();
        test_backpressure();
        test_reset_mid();
        test_drop();
        test_burst1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Round-robin arbiter sharing one wide coefficient stream (e.g. the input of stream_dispatch) between IN_NB requesters.
- Grants are burst-granular: once a requester is granted, it owns the output for exactly BURST_NB accepted beats. This keeps DISP_COEF-aligned words from different sources from interleaving.
- Sits directly upstream of stream_dispatch. Output is valid/ready, with an optional register stage.

Parameters:
- OP_W, 32, coefficient width in bits
- COEF, 16, coefficients per beat
- IN_NB, 4, number of requesters (>=2)
- BURST_NB, 8, beats per grant (>=1)
- OUT_PIPE, 1, 1 = registered output stage; 0 = combinational pass-through

Ports:
- clk  in  1  clock
- s_rst  in  1  synchronous reset, active-high
- in_data  in  [IN_NB][COEF][OP_W]  requester data
- in_vld  in  [IN_NB]  requester valid
- in_rdy  out  [IN_NB]  requester ready
- out_data  out  [COEF][OP_W]  granted data
- out_vld  out  1  output valid
- out_rdy  in  1  output ready
- out_src  out  $clog2(IN_NB)  index of the source of the current out beat
- out_last  out  1  last beat of the burst
- error  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset is synchronous and active-high; s_rst=1 at a clk edge resets the block.
- Reset values:
  - state=IDLE, beat_cnt=0, rr_ptr=IN_NB-1 (so requester 0 has first priority)
  - output register empty; out_vld=0, out_src=0, out_last=0, error=0
- Reset mid-burst aborts the burst; beats not yet accepted are not emitted.
- Downstream ready:
  - acc_rdy = out_rdy when OUT_PIPE=0
  - acc_rdy = (!out_vld || out_rdy) when OUT_PIPE=1
- IDLE state:
  - Winner = first index with in_vld=1 scanning rr_ptr+1, rr_ptr+2, … modulo IN_NB.
  - in_rdy[winner]=acc_rdy; all other in_rdy=0.
  - If no in_vld is set, all in_rdy=0 and the state stays IDLE.
  - On acceptance (in_vld[winner]&&in_rdy[winner]): grant<=winner, rr_ptr<=winner, beat_cnt<=1, and state goes to BURST.
  - If BURST_NB==1, state stays IDLE instead.
- BURST state:
  - in_rdy[grant]=acc_rdy; all others 0.
  - in_vld on other requesters is ignored.
  - Each accepted beat increments beat_cnt.
  - Acceptance with beat_cnt==BURST_NB-1: beat_cnt<=0, state<=IDLE.
- No bubble between bursts: the cycle after a last beat (IDLE) arbitrates and accepts in the same cycle. Full throughput is 1 beat/cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,IN_NB-1,0,…
- out_last=1 on the beat for which the burst counter reaches BURST_NB-1, including BURST_NB==1.
- out_src = index of the requester that supplied the beat.
- OUT_PIPE=1:
  - The accepted beat, out_src and out_last are registered; out_vld rises 1 cycle after acceptance.
  - Registered fields hold stable while out_vld && !out_rdy.
  - Register reloads on acceptance when empty or when out_rdy=1.
- OUT_PIPE=0: out_* are combinational from the granted input; out_vld = in_vld[sel] in the current state.
- Simultaneous events: an in_vld rising on a non-granted requester during the last beat is considered only in the following IDLE cycle.

Optional Feature:
- Macro STREAM_RR_ARB_CHECK_EN.
- Defined:
  - In BURST, in_vld[grant] falling to 0 before the burst completes sets error<=1 (sticky until s_rst).
  - Simulation $error message gives time and grant index.
  - Arbitration is unaffected; the burst simply stalls until in_vld returns.
- Undefined: error is tied to 0 and no check logic is synthesized.

Test Plan:
- Single requester 2 valid, 3 bursts with counter data -> 24 beats out, all out_src=2, out_last on beats 8/16/24, no gaps with out_rdy=1.
- All 4 requesters continuously valid, 16 bursts -> out_src sequence 0×8,1×8,2×8,3×8 repeated 4 times; throughput 128 beats in 128+OUT_PIPE cycles.
- Requester 1 valid mid-burst of requester 0 -> no interleave; requester 1's first beat is accepted the cycle after requester 0's 8th beat.
- Random out_rdy (50%), random in_vld, 10000 beats -> per-source data order preserved, every burst exactly 8 contiguous beats; scoreboard matches.
- s_rst asserted after beat 3 of a burst -> next cycle out_vld=0, all in_rdy=0; after release requester 0 wins first; the stale burst is not resumed.
- With STREAM_RR_ARB_CHECK_EN, drop in_vld[grant] at beat 4 -> error=1 next cycle, stays 1; burst resumes and completes at 8 beats when in_vld returns.
